switch_conditioner: RTL and testbench



---
 rtl/switch_conditioner_pkg.sv | 33 +++
 rtl/switch_conditioner_sync2.sv | 25 ++
 rtl/switch_conditioner.sv | 95 +++++++++
 tb/tb_switch_conditioner.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/switch_conditioner_pkg.sv
// Shared constants and types for the switch input conditioner.
// Imported by the RTL and the testbench so both agree on sizes.
package switch_conditioner_pkg;

  localparam int SW_WIDTH                 = 8;
  localparam int SW_STABLE_CYCLES_DEFAULT = 50_000;
  localparam int SW_CNT_W                 = 16;

  // Per-edge decision of the debounce datapath, highest priority first.
  typedef enum logic [1:0] {
    ACT_LOAD   = 2'd0,
    ACT_COUNT  = 2'd1,
    ACT_COMMIT = 2'd2,
    ACT_HOLD   = 2'd3
  } sw_act_e;

  // Bits that went 0->1 between two words.
  function automatic logic [SW_WIDTH-1:0] sw_rise(
    input logic [SW_WIDTH-1:0] nxt,
    input logic [SW_WIDTH-1:0] cur
  );
    return nxt & ~cur;
  endfunction

  // Bits that went 1->0 between two words.
  function automatic logic [SW_WIDTH-1:0] sw_fall(
    input logic [SW_WIDTH-1:0] nxt,
    input logic [SW_WIDTH-1:0] cur
  );
    return ~nxt & cur;
  endfunction

endpackage

// File: rtl/switch_conditioner_sync2.sv
// Two-flop synchroniser for a whole switch bus.
// Each bit is synchronised independently; the debouncer restores word coherence.
module sync2_bus #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] sync1;

  // Capture the asynchronous bus and retime it through a second flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      q     <= '0;
    end else begin
      sync1 <= d;
      q     <= sync1;
    end
  end

endmodule

// File: rtl/switch_conditioner.sv
// Synchronise and word-debounce the switch bus, then publish a stable
// byte with a one-cycle change strobe and per-bit edge pulses.
module switch_conditioner
  import switch_conditioner_pkg::*;
#(
  parameter int WIDTH         = SW_WIDTH,
  parameter int STABLE_CYCLES = SW_STABLE_CYCLES_DEFAULT,
  parameter int CNT_W         = SW_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic [WIDTH-1:0] raw_in,
  output logic [WIDTH-1:0] stable_out,
  output logic             changed,
  output logic [WIDTH-1:0] rose,
  output logic [WIDTH-1:0] fell
);

  if (STABLE_CYCLES < 1 ||
      ((longint'(STABLE_CYCLES) - 1) >> CNT_W) != 0) begin : g_bad_cfg
    $error("STABLE_CYCLES-1 must fit in CNT_W bits");
  end

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

  logic [WIDTH-1:0] sync2;
  logic [WIDTH-1:0] cand;
  logic [CNT_W-1:0] cnt;
  sw_act_e          act;
  logic             at_max;
  logic             differs;

  sync2_bus #(
    .WIDTH (WIDTH)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (raw_in),
    .q     (sync2)
  );

  assign at_max  = (cnt == CNT_MAX);
  assign differs = (cand != stable_out);

  // Pick this edge's action; a new candidate always wins, even with ena low.
  always_comb begin
    act = ACT_HOLD;
    if (sync2 != cand) begin
      act = ACT_LOAD;
    end else if (ena && !at_max) begin
      act = ACT_COUNT;
    end else if (ena && at_max && differs) begin
      act = ACT_COMMIT;
    end
  end

  // Candidate, stability counter and committed outputs with one-cycle pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cand       <= '0;
      cnt        <= '0;
      stable_out <= '0;
      changed    <= 1'b0;
      rose       <= '0;
      fell       <= '0;
    end else begin
      changed <= 1'b0;
      rose    <= '0;
      fell    <= '0;
      unique case (act)
        ACT_LOAD: begin
          cand <= sync2;
          cnt  <= '0;
        end
        ACT_COUNT: begin
          cnt <= cnt + 1'b1;
        end
        ACT_COMMIT: begin
          stable_out <= cand;
          changed    <= 1'b1;
          rose       <= cand & ~stable_out;
          fell       <= ~cand & stable_out;
        end
        ACT_HOLD: begin
          cnt <= cnt;
        end
        default: begin
          cnt <= cnt;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_switch_conditioner.sv
// Self-checking bench: vector tables, directed corner sequences,
// and randomized traffic against a raw-history reference model.
module tb_switch_conditioner;
  import switch_conditioner_pkg::*;

  localparam int S = 4;

  logic                clk;
  logic                rst_n;
  logic                ena;
  logic [SW_WIDTH-1:0] raw_in;
  logic [SW_WIDTH-1:0] stable_out;
  logic                changed;
  logic [SW_WIDTH-1:0] rose;
  logic [SW_WIDTH-1:0] fell;

  int tests = 0;
  int fails = 0;

  switch_conditioner #(
    .WIDTH         (SW_WIDTH),
    .STABLE_CYCLES (S),
    .CNT_W         (SW_CNT_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .raw_in     (raw_in),
    .stable_out (stable_out),
    .changed    (changed),
    .rose       (rose),
    .fell       (fell)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] raw;
    logic       en;
    logic [7:0] st;
    logic       ch;
    logic [7:0] ro;
    logic [7:0] fe;
  } vec_t;

  vec_t tab[$];

  // Reference model: raw history per edge plus the age of the value
  // that has sat at the debouncer input, counted in enabled edges.
  logic [7:0] h1, h2, h3;
  int         age;
  logic [7:0] m_st, m_ro, m_fe;
  logic       m_ch;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h1 = 0; h2 = 0; h3 = 0; age = 0;
      m_st = 0; m_ch = 0; m_ro = 0; m_fe = 0;
    end else begin
      m_ch = 0; m_ro = 0; m_fe = 0;
      if (h2 != h3) begin
        age = 0;
      end else if (ena && age < S - 1) begin
        age = age + 1;
      end else if (ena && h3 != m_st) begin
        m_ch = 1;
        for (int b = 0; b < 8; b++) begin
          m_ro[b] = h3[b] && !m_st[b];
          m_fe[b] = !h3[b] && m_st[b];
        end
        m_st = h3;
      end
      h3 = h2; h2 = h1; h1 = raw_in;
    end
  end

  task automatic check(input string nm, input logic [7:0] s,
                       input logic c, input logic [7:0] r,
                       input logic [7:0] f);
    tests++;
    if (stable_out !== s || changed !== c || rose !== r || fell !== f) begin
      fails++;
      $display("FAIL %s: got st=%h ch=%b ro=%h fe=%h want st=%h ch=%b ro=%h fe=%h",
               nm, stable_out, changed, rose, fell, s, c, r, f);
    end
  endtask

  task automatic apply(input logic [7:0] r, input logic e);
    raw_in = r;
    ena    = e;
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic [7:0] r, input logic e, input logic [7:0] s,
                     input logic c, input logic [7:0] ro, input logic [7:0] fe);
    vec_t v;
    v.raw = r; v.en = e; v.st = s; v.ch = c; v.ro = ro; v.fe = fe;
    tab.push_back(v);
  endtask

  initial begin
    logic [7:0] vals [5];
    logic [7:0] v;
    int         hold;
    logic       e;

    // Clean step 0x00->0x2A: commit on edge 7.
    for (int i = 1; i <= 9; i++) begin
      if (i < 7)       add(8'h2A, 1, 8'h00, 0, 8'h00, 8'h00);
      else if (i == 7) add(8'h2A, 1, 8'h2A, 1, 8'h2A, 8'h00);
      else             add(8'h2A, 1, 8'h2A, 0, 8'h00, 8'h00);
    end
    // Step 0x00->0xF0 with ena low on edges 4..8: commit on edge 12.
    for (int i = 1; i <= 14; i++) begin
      e = !(i >= 4 && i <= 8);
      if (i < 12)       add(8'hF0, e, 8'h00, 0, 8'h00, 8'h00);
      else if (i == 12) add(8'hF0, e, 8'hF0, 1, 8'hF0, 8'h00);
      else              add(8'hF0, e, 8'hF0, 0, 8'h00, 8'h00);
    end

    rst_n  = 1'b0;
    ena    = 1'b1;
    raw_in = 8'h00;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    #1 check("reset_state", 8'h00, 0, 8'h00, 8'h00);
    for (int i = 0; i < 8; i++) begin
      apply(8'h00, 1);
      check("idle_zero", 8'h00, 0, 8'h00, 8'h00);
    end

    for (int i = 0; i < 9; i++) begin
      apply(tab[i].raw, tab[i].en);
      check($sformatf("step_%0d", i + 1), tab[i].st, tab[i].ch,
            tab[i].ro, tab[i].fe);
    end

    for (int i = 0; i < 3; i++) begin
      apply(8'h00, 1);
      check("glitch_low", 8'h2A, 0, 8'h00, 8'h00);
    end
    for (int i = 0; i < 12; i++) begin
      apply(8'h2A, 1);
      check("glitch_back", 8'h2A, 0, 8'h00, 8'h00);
    end

    raw_in = 8'h00;
    #2 rst_n = 1'b0;
    #1 check("async_reset", 8'h00, 0, 8'h00, 8'h00);
    apply(8'h00, 1);
    check("in_reset", 8'h00, 0, 8'h00, 8'h00);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      apply(8'h00, 1);
      check("post_reset_quiet", 8'h00, 0, 8'h00, 8'h00);
    end

    for (int i = 9; i < tab.size(); i++) begin
      apply(tab[i].raw, tab[i].en);
      check($sformatf("ena_%0d", i - 8), tab[i].st, tab[i].ch,
            tab[i].ro, tab[i].fe);
    end

    // Return to zero so the bounce starts from a known committed value.
    for (int i = 0; i < 10; i++) apply(8'h00, 1);
    check("back_to_zero", 8'h00, 0, 8'h00, 8'h00);

    for (int i = 1; i <= 20; i++) begin
      v = (i <= 8 && ((i - 1) / 2) % 2 == 1) ? 8'h00 : 8'h01;
      if (i > 10) v = 8'h01;
      apply(v, 1);
      if (i < 15)       check("bounce_wait", 8'h00, 0, 8'h00, 8'h00);
      else if (i == 15) check("bounce_commit", 8'h01, 1, 8'h01, 8'h00);
      else              check("bounce_after", 8'h01, 0, 8'h00, 8'h00);
    end

    for (int i = 1; i <= 5; i++) begin
      apply(8'h81, 1);
      check("midcnt_pre", 8'h01, 0, 8'h00, 8'h00);
    end
    #2 rst_n = 1'b0;
    #1 check("midcnt_reset", 8'h00, 0, 8'h00, 8'h00);
    for (int i = 0; i < 2; i++) begin
      apply(8'h81, 1);
      check("midcnt_held", 8'h00, 0, 8'h00, 8'h00);
    end
    rst_n = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      apply(8'h81, 1);
      if (i < 7)       check("midcnt_wait", 8'h00, 0, 8'h00, 8'h00);
      else if (i == 7) check("midcnt_commit", 8'h81, 1, 8'h81, 8'h00);
      else             check("midcnt_after", 8'h81, 0, 8'h00, 8'h00);
    end

    vals[0] = 8'h00; vals[1] = 8'h2A; vals[2] = 8'hF0;
    vals[3] = 8'h81; vals[4] = 8'hFF;
    for (int n = 0; n < 1200; ) begin
      v    = vals[$urandom_range(0, 4)];
      hold = $urandom_range(1, 9);
      for (int k = 0; k < hold; k++) begin
        e = ($urandom_range(0, 5) != 0);
        apply(v, e);
        check("random", m_st, m_ch, m_ro, m_fe);
        tests++;
        if ((rose & fell) !== 8'h00) begin
          fails++;
          $display("FAIL rose_fell_overlap: got %h want 00", rose & fell);
        end
        n++;
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
